// File: rtl/ibex_clmul_seq.sv
// Purpose      : digit-serial carry-less (GF(2)) multiplier, clmul / clmulh / clmulr result modes.
// Latency      : WIDTH/DIGIT busy cycles, out_valid_o rises on the last busy edge (fewer with IBEX_CLMUL_EARLY_TERM_EN).
// Backpressure : one op in flight; in_ready_o low from accept to result handshake, result held in DONE until out_ready_i.
//
// Optional build macro IBEX_CLMUL_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits are all zero (at least one BUSY cycle always runs). Results are unchanged.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o  request handshake carrying a_i, b_i, op_i
//   op_i                     00 clmul, 01 clmulh, 10 clmulr, 11 executes as clmul
//   flush_i                  abort any in-flight op, back to IDLE next cycle
//   out_valid_o / out_ready_i result handshake carrying result_o
module ibex_clmul_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_digit_chk
        $error("ibex_clmul_seq: DIGIT must divide WIDTH");
    end
    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_width_chk
        $error("ibex_clmul_seq: WIDTH must be 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] a_q;      // multiplicand, pre-shifted by DIGIT each busy cycle
    logic [WIDTH-1:0]   b_q;      // multiplier, consumed from the bottom
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] p_q;      // product accumulator
    logic [CW-1:0]      cnt_q;

    logic [2*WIDTH-1:0] p_nxt;
    logic [2*WIDTH-1:0] a_shift;
    logic [WIDTH-1:0]   b_shift;
    logic [WIDTH-1:0]   res_nxt;
    logic               last_step;

    // One digit of the schoolbook product: XOR in A<<k for every set bit k of the low digit of B.
    always_comb begin
        p_nxt = p_q;
        for (int k = 0; k < DIGIT; k++) begin
            if (b_q[k]) begin
                p_nxt = p_nxt ^ (a_q << k);
            end
        end
    end

    assign a_shift = a_q << DIGIT;
    assign b_shift = b_q >> DIGIT;

`ifdef IBEX_CLMUL_EARLY_TERM_EN
    // Once no multiplier bits remain, further steps cannot change P.
    assign last_step = (cnt_q == LAST_CNT) || (b_shift == '0);
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    // Result slice taken from the product being written on the final busy edge.
    // P[2W-1] is always zero, so clmulh's top bit is 0.
    always_comb begin
        res_nxt = p_nxt[WIDTH-1:0];
        case (op_q)
            2'b01:   res_nxt = p_nxt[2*WIDTH-1:WIDTH];
            2'b10:   res_nxt = p_nxt[2*WIDTH-2:WIDTH-1];
            default: res_nxt = p_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'b00;
            p_q         <= '0;
            cnt_q       <= '0;
        end else if (flush_i) begin
            // result_o deliberately keeps its last value; it is don't-care while out_valid_o is low.
            state_q     <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        a_q        <= {{WIDTH{1'b0}}, a_i};
                        b_q        <= b_i;
                        op_q       <= op_i;
                        p_q        <= '0;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_o <= 1'b0;
                    end
                end
                BUSY: begin
                    p_q   <= p_nxt;
                    a_q   <= a_shift;
                    b_q   <= b_shift;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q     <= DONE;
                        out_valid_o <= 1'b1;
                        result_o    <= res_nxt;
                    end
                end
                DONE: begin
                    // in_ready_o stays low here, so a new request waits one cycle after the handshake.
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
